axi_mem_scrubber: RTL and testbench
===================================

Name: axi_mem_scrubber

Overview:
- Parametrised AXI4 write-path memory scrubber/initialiser.
- Fills the byte range [start_addr, end_addr) with a replicated 32-bit pattern, using multi-beat bursts with up to MAX_OUTSTANDING writes in flight.
- Reports progress on scrb_bus_t-style status signals (enable/addr/state/done), plus sticky error and optional cycle counter.
- Sits between the CL control logic and one DDR AXI slave port (AW/W/B only; AR/R are not used).

Parameters:
- DATA_W, 512, AXI data width in bits; power of two, 32..1024.
- ADDR_W, 64, AXI address width.
- ID_W, 16, AXI ID width.
- SCRB_ID, 0, constant awid/wid value.
- BURST_LEN, 64, max beats per burst; power of two, 1..256; BURST_LEN*DATA_W/8 <= 4096.
- MAX_OUTSTANDING, 4, max AW accepted without B; 1..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- enable  in  1  level; rising while IDLE starts a run
- start_addr  in  ADDR_W  first byte address; DATA_W/8-aligned
- end_addr  in  ADDR_W  exclusive end; DATA_W/8-aligned
- pattern  in  32  fill word, replicated across wdata
- awid/awaddr/awlen/awsize/awvalid  out  ID_W/ADDR_W/8/3/1  AXI AW
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/DATA_W/DATA_W/8/1/1  AXI W
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1  AXI B
- bready  out  1
- addr  out  ADDR_W  next awaddr to issue
- state  out  3  FSM state encoding
- done  out  1  run completed
- error  out  1  sticky; any bresp != 0 during run

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all valids 0, bready 0, addr 0, state IDLE, done 0, error 0.
- State encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3, ABORT=4.
- Start: enable rising edge in IDLE latches start/end/pattern, clears error, sets addr=start_addr.
  - end_addr <= start_addr -> DONE next cycle, no AXI traffic.
- Burst sizing:
  - burst bytes BB = BURST_LEN*DATA_W/8.
  - beats = min(BURST_LEN, (BB - addr mod BB)/(DATA_W/8), (end-addr)/(DATA_W/8)).
  - Bursts therefore never cross a BB (hence 4KB) boundary; the first and last bursts may be short.
  - awlen = beats-1; awsize = log2(DATA_W/8); wstrb all ones; wdata = {DATA_W/32{pattern}}; awid = wid = SCRB_ID.
- RUN:
  - awvalid asserts when no W burst is pending and outstanding < MAX_OUTSTANDING.
  - On AW handshake: addr += beats*DATA_W/8, outstanding++, W burst armed.
  - W beats are driven only after their AW has been accepted; wlast on the final beat.
  - awvalid and wvalid, once asserted, hold with stable payload until ready.
- bready: held 1 in RUN, DRAIN and ABORT.
  - B handshake decrements outstanding; simultaneous AW and B handshakes leave it unchanged.
  - bresp != 0 sets error (sticky until next start).
- RUN -> DRAIN: after the AW handshake where addr reaches end_addr.
- DRAIN -> DONE: when the W burst is complete and outstanding == 0.
- DONE: done=1 while enable is high; enable low -> IDLE, done=0.
- enable low during RUN -> ABORT:
  - no new AW; the pending W burst completes; wait until outstanding == 0.
  - then -> IDLE with done=0. addr holds its last value.
- enable re-rising during ABORT or DONE is ignored until the FSM reaches IDLE.
- Unexpected bvalid in IDLE is accepted (bready=0, so it stalls); no state change.
- Reset mid-run: immediate return to reset values. In-flight AXI transactions are abandoned; the slave must be reset together with this block.

Optional Feature:
- Macro: VSI_SCRB_PERF_CNT_EN.
- Defined:
  - adds output cycles[31:0], cleared on start.
  - increments each cycle in RUN/DRAIN; saturates at all-ones; holds in DONE/ABORT/IDLE.
- Undefined: port absent, no counter logic.

Decomposition:
- Package vsi_scrb_pkg holds:
  - typedef enum logic[2:0] scrb_state_t (IDLE..ABORT);
  - localparam helpers for beat bytes and log2 size;
  - AXI resp constant OKAY=2'b00.
- Sub-module axi_scrb_burst_calc: combinational beats/awlen calculation from addr, end and parameters. Kept separate so it can be unit-tested.

Test Plan:
- Aligned run, DATA_W=512, start 0x0, end 0x2000, ready always 1 -> 2 bursts, awlen=63, awaddr 0x0 then 0x1000, 128 W beats, done=1, error=0.
- Unaligned run, start 0xFC0, end 0x1080 -> bursts awaddr 0xFC0 awlen=0, then 0x1000 awlen=1; wlast on beats 1 and 3.
- Outstanding limit, MAX_OUTSTANDING=2, bvalid withheld, range 0x0..0x4000 -> exactly 2 AW handshakes, awvalid low; releasing B resumes issue.
- Error: bresp=2'b10 on the 2nd B -> error=1 stays set, run still reaches DONE; next start clears error.
- Abort: enable low mid-W of burst 1 -> W burst finishes with wlast, no further AW, IDLE after last B, done=0.
- Backpressure: random awready/wready stalls -> payload stable while valid high; total W beats equal (end-start)/64; with VSI_SCRB_PERF_CNT_EN defined, cycles equals the RUN+DRAIN cycle count.

Source files
------------

// File: rtl/axi_mem_scrubber_pkg.sv
`default_nettype none
// ============================================================================
// Module : vsi_scrb_pkg
// Brief  : Shared types, AXI constants and width helpers for the memory scrubber.
// Rev    : 1.0  initial release
// ============================================================================
package vsi_scrb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } scrb_state_t;

    localparam logic [1:0] c_AXI_RESP_OKAY = 2'b00;

    function automatic int beat_bytes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int size_log2(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_scrubber_if.sv
`default_nettype none
// ============================================================================
// Module : axi_mem_scrubber_if
// Brief  : AXI4 write-channel bundle (AW/W/B) between scrubber and DDR slave.
// Rev    : 1.0  initial release
// ============================================================================
interface axi_mem_scrubber_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 16
) ();
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awvalid,
        output wid, wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_mem_scrubber_burst_calc.sv
`default_nettype none
// ============================================================================
// Module : axi_scrb_burst_calc
// Brief  : Beats for the next burst: limited by BURST_LEN, the burst-size
//          boundary and the bytes left before the end address.
// Rev    : 1.0  initial release
// ============================================================================
module axi_scrb_burst_calc
    import vsi_scrb_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 64,
    parameter int BURST_LEN = 64
) (
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [ADDR_W-1:0] i_end_addr,
    output logic      [8:0]        o_beats,
    output logic      [7:0]        o_awlen
);
    localparam int c_LOG2B = size_log2(DATA_W);

    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_to_bnd;
    logic [ADDR_W-1:0] w_remain;
    logic [ADDR_W-1:0] w_min;

    // Beat offset inside the current BURST_LEN-beat window; the window never
    // exceeds 4KB, so staying inside it also keeps bursts off 4KB crossings.
    assign w_off    = (i_addr >> c_LOG2B) & ADDR_W'(BURST_LEN - 1);
    assign w_to_bnd = ADDR_W'(BURST_LEN) - w_off;
    assign w_remain = (i_end_addr - i_addr) >> c_LOG2B;

    always_comb begin
        w_min = w_to_bnd;
        if (w_remain < w_min) begin
            w_min = w_remain;
        end
    end

    assign o_beats = 9'(w_min);
    assign o_awlen = 8'(w_min - ADDR_W'(1));
endmodule
`default_nettype wire

// File: rtl/axi_mem_scrubber.sv
`default_nettype none
// ============================================================================
// Module : axi_mem_scrubber
// Brief  : AXI4 write-path fill engine; writes a replicated 32-bit pattern over
//          [start_addr, end_addr). Optional cycle counter: VSI_SCRB_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module axi_mem_scrubber
    import vsi_scrb_pkg::*;
#(
    parameter int DATA_W          = 512,
    parameter int ADDR_W          = 64,
    parameter int ID_W            = 16,
    parameter int SCRB_ID         = 0,
    parameter int BURST_LEN       = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
`ifdef VSI_SCRB_PERF_CNT_EN
    output logic [31:0]            cycles,
`endif
    input  wire logic              enable,
    input  wire logic [ADDR_W-1:0] start_addr,
    input  wire logic [ADDR_W-1:0] end_addr,
    input  wire logic [31:0]       pattern,
    axi_mem_scrubber_if.master     axi,
    output logic [ADDR_W-1:0]      addr,
    output logic [2:0]             state,
    output logic                   done,
    output logic                   error
);
    localparam int c_LOG2B = size_log2(DATA_W);
    localparam int c_OSW   = $clog2(MAX_OUTSTANDING + 1);

    scrb_state_t       r_state;
    logic              r_en_d;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_end;
    logic [31:0]       r_pattern;
    logic              r_awvalid;
    logic [ADDR_W-1:0] r_awaddr;
    logic [7:0]        r_awlen;
    logic              r_wvalid;
    logic              r_wlast;
    logic [8:0]        r_wleft;
    logic              r_wpend;
    logic [c_OSW-1:0]  r_outst;
    logic              r_bready;
    logic              r_done;
    logic              r_error;

    logic [8:0]        w_beats;
    logic [7:0]        w_awlen;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_start;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_issue_ok;
    logic              w_quiet;
    logic              w_unused;

    axi_scrb_burst_calc #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_calc (
        .i_addr     (r_addr),
        .i_end_addr (r_end),
        .o_beats    (w_beats),
        .o_awlen    (w_awlen)
    );

    assign w_start     = enable && !r_en_d && (r_state == ST_IDLE);
    assign w_aw_hs     = r_awvalid && axi.awready;
    assign w_w_hs      = r_wvalid && axi.wready;
    assign w_b_hs      = axi.bvalid && r_bready;
    // r_addr only moves on the AW handshake, so w_beats still matches the burst in flight.
    assign w_next_addr = r_addr + (ADDR_W'(w_beats) << c_LOG2B);
    assign w_issue_ok  = (r_state == ST_RUN) && enable && !r_awvalid && !r_wpend
                         && (r_outst < c_OSW'(MAX_OUTSTANDING)) && (r_addr < r_end);
    assign w_quiet     = !r_awvalid && !r_wpend && (r_outst == '0);
    assign w_unused    = ^axi.bid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_en_d    <= 1'b0;
            r_addr    <= '0;
            r_end     <= '0;
            r_pattern <= '0;
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_wleft   <= '0;
            r_wpend   <= 1'b0;
            r_outst   <= '0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_en_d <= enable;

            if (w_aw_hs && !w_b_hs) begin
                r_outst <= r_outst + c_OSW'(1);
            end else if (!w_aw_hs && w_b_hs) begin
                r_outst <= r_outst - c_OSW'(1);
            end
            if (w_b_hs && (axi.bresp != c_AXI_RESP_OKAY)) begin
                r_error <= 1'b1;
            end

            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_addr    <= w_next_addr;
                r_wpend   <= 1'b1;
                r_wvalid  <= 1'b1;
                r_wleft   <= {1'b0, r_awlen} + 9'd1;
                r_wlast   <= (r_awlen == 8'd0);
            end else if (w_issue_ok) begin
                r_awvalid <= 1'b1;
                r_awaddr  <= r_addr;
                r_awlen   <= w_awlen;
            end

            if (w_w_hs) begin
                if (r_wlast) begin
                    r_wvalid <= 1'b0;
                    r_wpend  <= 1'b0;
                    r_wlast  <= 1'b0;
                end else begin
                    r_wleft <= r_wleft - 9'd1;
                    r_wlast <= (r_wleft == 9'd2);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr    <= start_addr;
                        r_end     <= end_addr;
                        r_pattern <= pattern;
                        r_error   <= 1'b0;
                        if (end_addr > start_addr) begin
                            r_state  <= ST_RUN;
                            r_bready <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        r_state <= ST_ABORT;
                    end else if (w_aw_hs && (w_next_addr == r_end)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_quiet) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_bready <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    if (w_quiet) begin
                        r_state  <= ST_IDLE;
                        r_bready <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VSI_SCRB_PERF_CNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (w_start) begin
            r_cycles <= '0;
        end else if (((r_state == ST_RUN) || (r_state == ST_DRAIN)) && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles = r_cycles;
`endif

    assign axi.awid    = ID_W'(SCRB_ID);
    assign axi.awaddr  = r_awaddr;
    assign axi.awlen   = r_awlen;
    assign axi.awsize  = 3'(c_LOG2B);
    assign axi.awvalid = r_awvalid;
    assign axi.wid     = ID_W'(SCRB_ID);
    assign axi.wdata   = {(DATA_W/32){r_pattern}};
    assign axi.wstrb   = '1;
    assign axi.wlast   = r_wlast;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;
    assign addr        = r_addr;
    assign state       = r_state;
    assign done        = r_done;
    assign error       = r_error;
endmodule
`default_nettype wire

// File: tb/tb_axi_mem_scrubber.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_mem_scrubber
// Brief  : Directed bench with a transaction-level model of the expected bursts.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_mem_scrubber;
    localparam int c_DW  = 512;
    localparam int c_MAX = 2;
    localparam int c_ID  = 5;

    typedef struct {
        logic [63:0] a;
        int          len;
    } aw_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
    logic [31:0] pattern;
    logic [63:0] addr;
    logic [2:0]  st;
    logic        done;
    logic        error;
    logic [31:0] cycles;

    axi_mem_scrubber_if #(.DATA_W(c_DW), .ADDR_W(64), .ID_W(16)) bus ();

    axi_mem_scrubber #(
        .DATA_W(c_DW), .ADDR_W(64), .ID_W(16), .SCRB_ID(c_ID),
        .BURST_LEN(64), .MAX_OUTSTANDING(c_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef VSI_SCRB_PERF_CNT_EN
        .cycles     (cycles),
`endif
        .enable     (enable),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .pattern    (pattern),
        .axi        (bus),
        .addr       (addr),
        .state      (st),
        .done       (done),
        .error      (error)
    );

    int n_chk = 0;
    int n_err = 0;
    aw_t         exp_aw[$];
    int          wlen_q[$];
    logic [63:0] aw_log[$];
    int          awlen_log[$];
    int          wlast_pos[$];
    int aw_cnt, w_beats, wlast_cnt, outst, beat_idx, b_avail, b_sent, err_b_idx, run_cyc;
    bit rnd_rdy, b_hold, b_fire;
    bit prev_aw_wait, prev_w_wait, prev_wlast;
    logic [63:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [31:0] cur_pat;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] aw_at(input int i);
        if (i < aw_log.size()) return aw_log[i];
        return '1;
    endfunction

    function automatic int len_at(input int i);
        if (i < awlen_log.size()) return awlen_log[i];
        return -1;
    endfunction

    function automatic int wl_at(input int i);
        if (i < wlast_pos.size()) return wlast_pos[i];
        return -1;
    endfunction

    // Expected burst list: 4KB windows of 64 beats x 64 bytes, clipped at the end address.
    task automatic build_model(input logic [63:0] s, input logic [63:0] e);
        logic [63:0] a;
        int bts;
        exp_aw.delete();
        a = s;
        while (a < e) begin
            bts = 64 - int'((a % 64'd4096) / 64'd64);
            if ((e - a) / 64 < 64'(bts)) bts = int'((e - a) / 64);
            exp_aw.push_back('{a: a, len: bts - 1});
            a = a + 64'(bts * 64);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave: readies, and one B per completed W burst.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (b_fire) begin
                bus.bvalid = 1'b0;
                b_fire     = 1'b0;
            end
            bus.awready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!bus.bvalid && !b_hold && (b_avail > 0)) begin
                b_avail--;
                b_sent++;
                bus.bvalid = 1'b1;
                bus.bid    = 16'(c_ID);
                bus.bresp  = (b_sent == err_b_idx) ? 2'b10 : 2'b00;
            end
        end
    end

    // Monitor / compare: handshakes are judged at negedge, ahead of the posedge that takes them.
    initial begin
        int wq_before;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                wq_before = wlen_q.size();
                chk("bready", 512'(bus.bready), 512'((st == 3'd1) || (st == 3'd2) || (st == 3'd4)));
                if ((st == 3'd1) || (st == 3'd2)) run_cyc++;

                if (prev_w_wait) chk("w_hold", {bus.wvalid, bus.wlast}, {1'b1, prev_wlast});
                if (bus.wvalid) begin
                    if (wq_before == 0) chk("w_before_aw", 1, 0);
                    else chk("wlast", 512'(bus.wlast), 512'(beat_idx == wlen_q[0]));
                    chk("wdata", bus.wdata, {16{cur_pat}});
                    chk("wstrb", 512'(bus.wstrb), {64{1'b1}});
                    chk("wid", 512'(bus.wid), 512'(c_ID));
                    if (bus.wready) begin
                        w_beats++;
                        prev_w_wait = 1'b0;
                        if (bus.wlast) begin
                            wlast_cnt++;
                            wlast_pos.push_back(w_beats);
                            beat_idx = 0;
                            if (wlen_q.size() > 0) void'(wlen_q.pop_front());
                            b_avail++;
                        end else begin
                            beat_idx++;
                        end
                    end else begin
                        prev_w_wait = 1'b1;
                        prev_wlast  = bus.wlast;
                    end
                end else begin
                    prev_w_wait = 1'b0;
                end

                if (prev_aw_wait) chk("aw_hold", {bus.awvalid, bus.awaddr, bus.awlen}, {1'b1, prev_awaddr, prev_awlen});
                if (bus.awvalid) begin
                    chk("aw_outst_limit", 512'(outst < c_MAX), 1);
                    chk("aw_w_pending", 512'(wq_before), 0);
                    chk("awid", 512'(bus.awid), 512'(c_ID));
                    chk("awsize", 512'(bus.awsize), 6);
                    if (bus.awready) begin
                        if (exp_aw.size() == 0) begin
                            chk("aw_extra", 1, 0);
                        end else begin
                            chk("awaddr", 512'(bus.awaddr), 512'(exp_aw[0].a));
                            chk("awlen", 512'(bus.awlen), 512'(exp_aw[0].len));
                            void'(exp_aw.pop_front());
                        end
                        aw_log.push_back(bus.awaddr);
                        awlen_log.push_back(int'(bus.awlen));
                        wlen_q.push_back(int'(bus.awlen));
                        aw_cnt++;
                        outst++;
                        prev_aw_wait = 1'b0;
                    end else begin
                        prev_aw_wait = 1'b1;
                        prev_awaddr  = bus.awaddr;
                        prev_awlen   = bus.awlen;
                    end
                end else begin
                    prev_aw_wait = 1'b0;
                end

                if (bus.bvalid && bus.bready) begin
                    outst--;
                    b_fire = 1'b1;
                end
            end
        end
    end

    task automatic start_run(input logic [63:0] s, input logic [63:0] e,
                             input logic [31:0] pat, input int err_idx);
        @(posedge clk);
        #1;
        build_model(s, e);
        aw_log.delete();
        awlen_log.delete();
        wlast_pos.delete();
        aw_cnt = 0; w_beats = 0; wlast_cnt = 0; run_cyc = 0;
        b_sent = 0; err_b_idx = err_idx;
        cur_pat = pat;
        start_addr = s;
        end_addr = e;
        pattern = pat;
        enable = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] want, input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (st == want) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 512'(ok), 1);
    endtask

    task automatic stop_run();
        @(posedge clk);
        #1;
        enable = 1'b0;
        wait_state(3'd0, 5, "to_idle_timeout");
        chk("done_after_idle", 512'(done), 0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; start_addr = '0; end_addr = '0; pattern = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        bus.bid = '0; bus.bresp = 2'b00;
        rnd_rdy = 1'b0; b_hold = 1'b0; b_fire = 1'b0;
        aw_cnt = 0; w_beats = 0; wlast_cnt = 0; outst = 0; beat_idx = 0;
        b_avail = 0; b_sent = 0; err_b_idx = 0; run_cyc = 0; cur_pat = '0;
        prev_aw_wait = 1'b0; prev_w_wait = 1'b0; prev_wlast = 1'b0;
        prev_awaddr = '0; prev_awlen = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", 512'(bus.awvalid), 0);
        chk("rst_wvalid", 512'(bus.wvalid), 0);
        chk("rst_bready", 512'(bus.bready), 0);
        chk("rst_addr", 512'(addr), 0);
        chk("rst_state", 512'(st), 0);
        chk("rst_done", 512'(done), 0);
        chk("rst_error", 512'(error), 0);
        rst_n = 1'b1;

        // Aligned fill: two full 4KB bursts
        start_run(64'h0, 64'h2000, 32'hA5A5_0001, 0);
        wait_state(3'd3, 2000, "t1_done_timeout");
        chk("t1_done", 512'(done), 1);
        chk("t1_error", 512'(error), 0);
        chk("t1_aw_cnt", 512'(aw_cnt), 2);
        chk("t1_aw0", 512'(aw_at(0)), 64'h0);
        chk("t1_len0", 512'(len_at(0)), 63);
        chk("t1_aw1", 512'(aw_at(1)), 64'h1000);
        chk("t1_len1", 512'(len_at(1)), 63);
        chk("t1_beats", 512'(w_beats), 128);
        chk("t1_addr", 512'(addr), 64'h2000);
        chk("t1_model_left", 512'(exp_aw.size()), 0);
        stop_run();

        // Unaligned start: 1-beat burst up to the 4KB line, then 2 beats
        start_run(64'hFC0, 64'h1080, 32'h1234_5678, 0);
        wait_state(3'd3, 500, "t2_done_timeout");
        chk("t2_aw0", 512'(aw_at(0)), 64'hFC0);
        chk("t2_len0", 512'(len_at(0)), 0);
        chk("t2_aw1", 512'(aw_at(1)), 64'h1000);
        chk("t2_len1", 512'(len_at(1)), 1);
        chk("t2_wlast0", 512'(wl_at(0)), 1);
        chk("t2_wlast1", 512'(wl_at(1)), 3);
        chk("t2_beats", 512'(w_beats), 3);
        stop_run();

        // Outstanding limit with B withheld
        b_hold = 1'b1;
        start_run(64'h0, 64'h4000, 32'h0F0F_F0F0, 0);
        repeat (300) @(negedge clk);
        #1;
        chk("t3_aw_cnt_held", 512'(aw_cnt), 2);
        chk("t3_awvalid_held", 512'(bus.awvalid), 0);
        chk("t3_wlast_held", 512'(wlast_cnt), 2);
        b_hold = 1'b0;
        wait_state(3'd3, 2000, "t3_done_timeout");
        chk("t3_aw_cnt", 512'(aw_cnt), 4);
        chk("t3_beats", 512'(w_beats), 256);
        stop_run();

        // Error response on the 2nd B
        start_run(64'h0, 64'h3000, 32'hDEAD_BEEF, 2);
        wait_state(3'd3, 2000, "t4_done_timeout");
        chk("t4_error", 512'(error), 1);
        chk("t4_done", 512'(done), 1);
        chk("t4_aw_cnt", 512'(aw_cnt), 3);
        stop_run();
        start_run(64'h0, 64'h1000, 32'hCAFE_F00D, 0);
        wait_state(3'd1, 5, "t4b_run_timeout");
        chk("t4b_error_cleared", 512'(error), 0);
        wait_state(3'd3, 1000, "t4b_done_timeout");
        chk("t4b_error", 512'(error), 0);
        stop_run();

        // Abort in the middle of the first W burst
        start_run(64'h0, 64'h4000, 32'h5555_AAAA, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (w_beats >= 10) break;
        end
        chk("t5_reached_mid_w", 512'(w_beats >= 10), 1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        wait_state(3'd0, 500, "t5_idle_timeout");
        chk("t5_aw_cnt", 512'(aw_cnt), 1);
        chk("t5_wlast_cnt", 512'(wlast_cnt), 1);
        chk("t5_beats", 512'(w_beats), 64);
        chk("t5_done", 512'(done), 0);
        chk("t5_addr", 512'(addr), 64'h1000);
        chk("t5_outst", 512'(outst), 0);
        repeat (3) @(posedge clk);

        // Empty range: DONE on the cycle after the start edge, no traffic
        start_run(64'h200, 64'h100, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t6_state", 512'(st), 3);
        chk("t6_done", 512'(done), 1);
        chk("t6_aw_cnt", 512'(aw_cnt), 0);
        stop_run();

        // Random backpressure on both request channels
        rnd_rdy = 1'b1;
        start_run(64'h40, 64'h2FC0, 32'h8421_1248, 0);
        wait_state(3'd3, 5000, "t7_done_timeout");
        chk("t7_beats", 512'(w_beats), (64'h2FC0 - 64'h40) / 64);
        chk("t7_aw_cnt", 512'(aw_cnt), 3);
        chk("t7_model_left", 512'(exp_aw.size()), 0);
        chk("t7_error", 512'(error), 0);
`ifdef VSI_SCRB_PERF_CNT_EN
        chk("t7_cycles", 512'(cycles), 512'(run_cyc));
`endif
        stop_run();
        rnd_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
